// File: rtl/uart_tx_engine.sv
// uart_tx_engine: transmit half of a 16550-style UART.
// Bytes written to the holding register (or the DEPTH-entry FIFO) are
// serialized on SOUT with start, data, parity and stop framing. Bit timing
// comes from a 16x baud tick.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   ThrWrite, TxData       one-cycle byte write into holding register/FIFO
//   BaudTick               16x baud-rate enable pulse
//   FifoEn, TxFifoClr      FCR[0] FIFO mode, FCR[2] FIFO clear strobe
//   Wls, Stb, Pen, Eps, Sp LCR frame format
//   Bc                     LCR[6] break (forces the line low)
//   Loop                   MCR[4] loopback (SOUT held high)
//   SOUT, SerialLoop       serial pin and internal loopback stream
//   THRE, TEMT, TXRDYb     transmitter status
module uart_tx_engine #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ThrWrite,
   input  logic [7:0] TxData,
   input  logic       BaudTick,
   input  logic       FifoEn,
   input  logic       TxFifoClr,
   input  logic [1:0] Wls,
   input  logic       Stb,
   input  logic       Pen,
   input  logic       Eps,
   input  logic       Sp,
   input  logic       Bc,
   input  logic       Loop,
   output logic       SOUT,
   output logic       SerialLoop,
   output logic       THRE,
   output logic       TEMT,
   output logic       TXRDYb
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // Parity of the first Wls+5 bits of a byte under the given LCR settings.
   function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] wls,
                                        input logic eps, input logic sp);
      logic x;
      x = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < (int'(wls) + 5)) x = x ^ d[i];
      end
      if (sp) return ~eps;
      return eps ? x : ~x;
   endfunction

   // Storage registers
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, cnt;
   logic          full;
   logic          fifo_en_q;

   // Serializer registers
   logic [2:0] state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [1:0] f_wls;
   logic       f_stb, f_pen, f_par;
   logic       line;

   // Next-state values
   logic [PW-1:0] wr_ptr_n, rd_ptr_n, cnt_n;
   logic          full_n, empty, empty_n, stor_full, clr, push, pop, load;
   logic [2:0]    state_n;
   logic [3:0]    tick_n;
   logic [2:0]    bit_n;
   logic [7:0]    shift_n, head;
   logic [1:0]    f_wls_n;
   logic          f_stb_n, f_pen_n, f_par_n, line_n;
   logic          last_bit, stop_end;
   logic          sout_n, loop_n, thre_n, temt_n, txrdy_n;

   assign empty     = (cnt == '0) && !full;
   assign stor_full = FifoEn ? full : (cnt != '0);
   // A change of FIFO mode flushes storage just like an explicit clear.
   assign clr       = TxFifoClr || (FifoEn != fifo_en_q);
   assign head      = mem[rd_ptr];

   // Frame sequencer: next state, bit timing and line value.
   always_comb begin
      state_n  = state;
      tick_n   = tick_cnt;
      bit_n    = bit_cnt;
      shift_n  = shift;
      f_wls_n  = f_wls;
      f_stb_n  = f_stb;
      f_pen_n  = f_pen;
      f_par_n  = f_par;
      line_n   = line;
      pop      = 1'b0;
      load     = 1'b0;
      last_bit = (bit_cnt == (3'(f_wls) + 3'd4));
      // bit_cnt counts whole 16-tick periods inside the stop bit(s).
      stop_end = (!f_stb && (tick_cnt == 4'd15)) ||
                 (f_stb && (f_wls == 2'd0) && (bit_cnt == 3'd1) && (tick_cnt == 4'd7)) ||
                 (f_stb && (f_wls != 2'd0) && (bit_cnt == 3'd1) && (tick_cnt == 4'd15));
      case (state)
         IDLE: begin
            if (BaudTick && !empty) load = 1'b1;
         end
         START: begin
            if (BaudTick) begin
               tick_n = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  state_n = DATA;
                  bit_n   = 3'd0;
                  line_n  = shift[0];
               end
            end
         end
         DATA: begin
            if (BaudTick) begin
               tick_n = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  if (last_bit) begin
                     if (f_pen) begin
                        state_n = PARITY;
                        line_n  = f_par;
                     end else begin
                        state_n = STOP;
                        bit_n   = 3'd0;
                        line_n  = 1'b1;
                     end
                  end else begin
                     bit_n   = bit_cnt + 3'd1;
                     shift_n = {1'b0, shift[7:1]};
                     line_n  = shift[1];
                  end
               end
            end
         end
         PARITY: begin
            if (BaudTick) begin
               tick_n = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  state_n = STOP;
                  bit_n   = 3'd0;
                  line_n  = 1'b1;
               end
            end
         end
         STOP: begin
            if (BaudTick) begin
               tick_n = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) bit_n = bit_cnt + 3'd1;
               if (stop_end) begin
                  if (!empty) begin
                     load = 1'b1;
                  end else begin
                     state_n = IDLE;
                     tick_n  = 4'd0;
                     bit_n   = 3'd0;
                     line_n  = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_n = IDLE;
            tick_n  = 4'd0;
            bit_n   = 3'd0;
            line_n  = 1'b1;
         end
      endcase
      // Pop the head byte and freeze the frame format for this frame.
      if (load) begin
         pop     = 1'b1;
         state_n = START;
         tick_n  = 4'd0;
         bit_n   = 3'd0;
         line_n  = 1'b0;
         shift_n = head;
         f_wls_n = Wls;
         f_stb_n = Stb;
         f_pen_n = Pen;
         f_par_n = calc_parity(head, Wls, Eps, Sp);
      end
   end

   // Storage bookkeeping and status next values.
   always_comb begin
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      cnt_n    = cnt;
      full_n   = full;
      push     = ThrWrite && (!stor_full || pop) && !clr;
      if (clr) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
         cnt_n    = '0;
         full_n   = 1'b0;
      end else begin
         if (push) wr_ptr_n = wr_ptr + PW'(1);
         if (pop)  rd_ptr_n = rd_ptr + PW'(1);
         if (push && !pop) begin
            // Count wraps to zero on reaching DEPTH; the full flag disambiguates.
            if (FifoEn && (cnt == PW'(DEPTH - 1))) begin
               full_n = 1'b1;
               cnt_n  = '0;
            end else begin
               cnt_n = cnt + PW'(1);
            end
         end else if (pop && !push) begin
            cnt_n  = cnt - PW'(1);
            full_n = 1'b0;
         end
      end
      empty_n = (cnt_n == '0) && !full_n;
      thre_n  = empty_n;
      temt_n  = empty_n && (state_n == IDLE);
      if (!FifoEn)      txrdy_n = ~empty_n;
      else if (full_n)  txrdy_n = 1'b1;
      else if (empty_n) txrdy_n = 1'b0;
      else              txrdy_n = TXRDYb;
      sout_n = Loop ? 1'b1 : (Bc ? 1'b0 : line_n);
      loop_n = Bc ? 1'b0 : line_n;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         full       <= 1'b0;
         fifo_en_q  <= FifoEn;
         state      <= IDLE;
         tick_cnt   <= 4'd0;
         bit_cnt    <= 3'd0;
         shift      <= 8'd0;
         f_wls      <= 2'd0;
         f_stb      <= 1'b0;
         f_pen      <= 1'b0;
         f_par      <= 1'b0;
         line       <= 1'b1;
         SOUT       <= 1'b1;
         SerialLoop <= 1'b1;
         THRE       <= 1'b1;
         TEMT       <= 1'b1;
         TXRDYb     <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_n;
         rd_ptr     <= rd_ptr_n;
         cnt        <= cnt_n;
         full       <= full_n;
         fifo_en_q  <= FifoEn;
         state      <= state_n;
         tick_cnt   <= tick_n;
         bit_cnt    <= bit_n;
         shift      <= shift_n;
         f_wls      <= f_wls_n;
         f_stb      <= f_stb_n;
         f_pen      <= f_pen_n;
         f_par      <= f_par_n;
         line       <= line_n;
         SOUT       <= sout_n;
         SerialLoop <= loop_n;
         THRE       <= thre_n;
         TEMT       <= temt_n;
         TXRDYb     <= txrdy_n;
      end
   end

   // FIFO storage array (no reset needed; validity tracked by pointers).
   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr] <= TxData;
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: self-checking bench for uart_tx_engine.
// A behavioural model keeps the queued bytes and the expected per-tick line
// levels of the frame in flight, and every cycle the DUT outputs are compared
// against it.
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       reset, ThrWrite, BaudTick, FifoEn, TxFifoClr;
   logic [7:0] TxData;
   logic [1:0] Wls;
   logic       Stb, Pen, Eps, Sp, Bc, Loop;
   logic       SOUT, SerialLoop, THRE, TEMT, TXRDYb;

   always #5 clk = ~clk;

   uart_tx_engine #(.DEPTH(16)) dut (
      .clk(clk), .reset(reset), .ThrWrite(ThrWrite), .TxData(TxData),
      .BaudTick(BaudTick), .FifoEn(FifoEn), .TxFifoClr(TxFifoClr),
      .Wls(Wls), .Stb(Stb), .Pen(Pen), .Eps(Eps), .Sp(Sp), .Bc(Bc), .Loop(Loop),
      .SOUT(SOUT), .SerialLoop(SerialLoop), .THRE(THRE), .TEMT(TEMT), .TXRDYb(TXRDYb)
   );

   // Model state
   logic [7:0] pend[$];     // bytes accepted but not yet started
   bit         stream[$];   // remaining line levels (one per tick) of current frame
   bit         cur;         // current model line level
   bit         busy;        // a frame is in flight
   bit         txr;         // model TXRDYb
   bit         fe_prev;
   int         asserts = 0;
   int         fails   = 0;

   task automatic chk(input string tag, input logic obs, input logic expv);
      asserts++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
      end
   endtask

   // Expand a byte into its per-tick line levels using the current LCR.
   function automatic void build_frame(input logic [7:0] b);
      int n;
      bit x;
      bit par;
      int stop_ticks;
      n = int'(Wls) + 5;
      x = 1'b0;
      repeat (16) stream.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         repeat (16) stream.push_back(b[i]);
         x = x ^ b[i];
      end
      if (Pen) begin
         if (Sp)       par = ~Eps;
         else if (Eps) par = x;
         else          par = ~x;
         repeat (16) stream.push_back(par);
      end
      stop_ticks = !Stb ? 16 : ((Wls == 2'd0) ? 24 : 32);
      repeat (stop_ticks) stream.push_back(1'b1);
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, check.
   task automatic step(input bit tk, input bit wr, input logic [7:0] d, input bit clr);
      int sz0;
      int cap;
      bit popped;
      bit clr_eff;
      BaudTick  = tk;
      ThrWrite  = wr;
      TxData    = d;
      TxFifoClr = clr;
      @(negedge clk);
      if (reset) begin
         pend.delete();
         stream.delete();
         cur  = 1'b1;
         busy = 1'b0;
         txr  = 1'b0;
      end else begin
         sz0     = pend.size();
         cap     = FifoEn ? 16 : 1;
         popped  = 1'b0;
         clr_eff = clr || (FifoEn != fe_prev);
         if (tk) begin
            if (stream.size() == 0) begin
               if (sz0 > 0) begin
                  build_frame(pend.pop_front());
                  popped = 1'b1;
               end else begin
                  busy = 1'b0;
               end
            end
            if (stream.size() != 0) begin
               cur  = stream.pop_front();
               busy = 1'b1;
            end
         end
         if (wr && (sz0 < cap || popped)) pend.push_back(d);
         if (clr_eff) pend.delete();
         if (!FifoEn)               txr = (pend.size() != 0);
         else if (pend.size() == 16) txr = 1'b1;
         else if (pend.size() == 0)  txr = 1'b0;
      end
      fe_prev = FifoEn;
      chk("sout",  SOUT,       reset ? 1'b1 : (Loop ? 1'b1 : (Bc ? 1'b0 : cur)));
      chk("sloop", SerialLoop, reset ? 1'b1 : (Bc ? 1'b0 : cur));
      chk("thre",  THRE,       pend.size() == 0);
      chk("temt",  TEMT,       (pend.size() == 0) && !busy);
      chk("txrdy", TXRDYb,     txr);
   endtask

   task automatic run(input int n, input int rate);
      for (int k = 0; k < n; k++) step($urandom_range(99) < rate, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 3500 && (busy || pend.size() != 0); k++) step(1'b1, 1'b0, 8'h00, 1'b0);
      run(4, 100);
   endtask

   task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                          input logic e, input logic st);
      Wls = w; Stb = s; Pen = p; Eps = e; Sp = st;
   endtask

   initial begin
      reset = 1'b1; ThrWrite = 1'b0; BaudTick = 1'b0; FifoEn = 1'b0; TxFifoClr = 1'b0;
      TxData = 8'h00; Bc = 1'b0; Loop = 1'b0;
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      fe_prev = 1'b0; cur = 1'b1; busy = 1'b0; txr = 1'b0;
      @(negedge clk);
      // Reset values
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      reset = 1'b0;
      run(3, 100);

      // Single 8N1 frame of 0x55 with a tick every cycle
      step(1'b0, 1'b1, 8'h55, 1'b0);
      drain();

      // Parity variants and 1.5 stop bits on 5-bit words
      set_lcr(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h07, 1'b0); drain();
      set_lcr(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h07, 1'b0); drain();
      set_lcr(2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h07, 1'b0); drain();
      set_lcr(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h07, 1'b0); drain();
      set_lcr(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'hC3, 1'b0); drain();

      // FIFO full: 17 writes with ticks idle, last one dropped
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      FifoEn = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      run(2, 0);
      drain();

      // Clear in the middle of the first frame's data bits
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      run(60, 100);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      drain();

      // Break during a frame
      step(1'b0, 1'b1, 8'h3C, 1'b0);
      run(40, 100);
      Bc = 1'b1;
      run(60, 100);
      Bc = 1'b0;
      drain();

      // Loopback: SOUT stays high, SerialLoop carries the frame
      Loop = 1'b1;
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      drain();
      Loop = 1'b0;

      // Reset during data bits abandons the frame
      step(1'b0, 1'b1, 8'h96, 1'b0);
      step(1'b0, 1'b1, 8'h69, 1'b0);
      run(50, 100);
      reset = 1'b1;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      reset = 1'b0;
      run(200, 100);

      // Randomized traffic, tick rates, LCR changes, break and loopback
      for (int it = 0; it < 12; it++) begin
         FifoEn = 1'($urandom_range(1));
         set_lcr(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
         step(1'b0, 1'b0, 8'h00, 1'b0);
         for (int b = 0; b < (FifoEn ? $urandom_range(5, 1) : 2); b++)
            step(1'b0, 1'b1, 8'($urandom), 1'b0);
         begin
            int rate;
            rate = $urandom_range(100, 30);
            for (int k = 0; k < 600; k++) begin
               if ($urandom_range(63) == 0) Bc = ~Bc;
               if ($urandom_range(63) == 0) Loop = ~Loop;
               if ($urandom_range(63) == 0)
                  set_lcr(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)));
               step($urandom_range(99) < rate, $urandom_range(31) == 0, 8'($urandom),
                    $urandom_range(255) == 0);
            end
         end
         Bc = 1'b0;
         Loop = 1'b0;
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
